// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback-port arbiter.
package wb_port_arbiter_pkg;

    localparam logic RESET = 1'b0;

    localparam int WB_ADDRESS_WIDTH = 5;
    localparam int WB_DATA_WIDTH    = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

    // Convenience bundle for requesters using the default widths.
    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] id;
        logic [WB_DATA_WIDTH-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last winner.
module rr_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] idx;
    logic          found;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        idx       = '0;
        if (rst != RESET) begin
            for (int i = 1; i <= N; i++) begin
                idx = ((int'(last_grant) + i) >= N) ? IW'(int'(last_grant) + i - N)
                                                    : IW'(int'(last_grant) + i);
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            last_grant <= LAST_IDX;
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: round-robin grant plus a registered register-file write stage.
// Optional stall counter enabled by defining WB_ARB_PERF_EN.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_SRC       = 3,
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int PERF_WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*ADDRESS_WIDTH-1:0] src_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic                            write_en,
    output logic [ADDRESS_WIDTH-1:0]        write_id,
    output logic [DATA_WIDTH-1:0]           write_data,
    output logic                            busy
`ifdef WB_ARB_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]           stall_count
`endif
);

    wb_state_t                state;
    wb_state_t                next_state;
    logic [NUM_SRC-1:0]       grant;
    logic                     handshake;
    logic [ADDRESS_WIDTH-1:0] sel_id;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     sel_nonzero;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (src_valid),
        .advance (handshake),
        .grant   (grant)
    );

    assign src_ready = grant;
    assign handshake = |(src_valid & grant);

    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant[k]) begin
                sel_id   = src_id[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data = src_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Writes to x0 complete the handshake but never reach the register file.
    assign sel_nonzero = (sel_id != '0);

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = (handshake && sel_nonzero) ? WRITE : IDLE;
    end

    always_comb begin
        write_en = (state == WRITE);
        busy     = write_en;
    end

    // Id/data hold their previous value when the stage is idle or absorbs an x0 write.
    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            write_id   <= '0;
            write_data <= '0;
        end else if (handshake && sel_nonzero) begin
            write_id   <= sel_id;
            write_data <= sel_data;
        end
    end

`ifdef WB_ARB_PERF_EN
    localparam int CW = $clog2(NUM_SRC + 1);

    logic [CW-1:0]         stalls;
    logic [PERF_WIDTH:0]   stall_sum;

    always_comb begin
        stalls = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            stalls = stalls + CW'(src_valid[k] & ~src_ready[k]);
        end
        stall_sum = {1'b0, stall_count} + (PERF_WIDTH+1)'(stalls);
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            stall_count <= '0;
        end else if (stall_sum[PERF_WIDTH]) begin
            stall_count <= '1;
        end else begin
            stall_count <= stall_sum[PERF_WIDTH-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized self-checking bench for wb_port_arbiter against a behavioural round-robin model.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int PW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      src_valid;
    logic [N*AW-1:0]   src_id;
    logic [N*DW-1:0]   src_data;
    logic [N-1:0]      src_ready;
    logic              write_en;
    logic [AW-1:0]     write_id;
    logic [DW-1:0]     write_data;
    logic              busy;
`ifdef WB_ARB_PERF_EN
    logic [PW-1:0]     stall_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_lg;
    logic        m_we;
    logic [AW-1:0] m_id;
    logic [DW-1:0] m_data;
    longint      m_stall;

    wb_port_arbiter #(
        .NUM_SRC(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PERF_WIDTH(PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_id     (src_id),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .write_en   (write_en),
        .write_id   (write_id),
        .write_data (write_data),
        .busy       (busy)
`ifdef WB_ARB_PERF_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input int lg, input logic r);
        logic [N-1:0] g;
        g = '0;
        if (r) begin
            for (int i = 1; i <= N; i++) begin
                if (v[(lg + i) % N]) begin
                    g[(lg + i) % N] = 1'b1;
                    return g;
                end
            end
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    task automatic set_src(input int k, input logic v, input logic [AW-1:0] id, input logic [DW-1:0] d);
        src_valid[k]           = v;
        src_id[k*AW +: AW]     = id;
        src_data[k*DW +: DW]   = d;
    endtask

    // Advance one clock and the model together; returns at posedge+1.
    task automatic tick();
        logic [N-1:0] g;
        int k;
        g = model_ready(src_valid, m_lg, rst);
        @(posedge clk);
        if (!rst) begin
            m_lg = N - 1; m_we = 1'b0; m_id = '0; m_data = '0; m_stall = 0;
        end else begin
            for (int j = 0; j < N; j++) if (src_valid[j] && !g[j]) m_stall++;
            if (m_stall > 64'hFFFF_FFFF) m_stall = 64'hFFFF_FFFF;
            k = onehot_idx(g);
            if (k >= 0) begin
                m_lg = k;
                if (src_id[k*AW +: AW] != '0) begin
                    m_we = 1'b1; m_id = src_id[k*AW +: AW]; m_data = src_data[k*DW +: DW];
                end else begin
                    m_we = 1'b0;
                end
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < N; k++) set_src(k, 1'b1, AW'(k + 1), DW'(32'hA000 + k));
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if (src_ready !== '0) begin
                miscompares++; $display("FAIL reset_ready got=%b want=%b", src_ready, 3'b000);
            end
            tick();
            vectors++;
            if (write_en !== 1'b0 || write_id !== '0 || write_data !== '0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out got we=%b id=%0d data=%h busy=%b want 0/0/0/0", write_en, write_id, write_data, busy);
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (src_ready !== 3'b001) begin
            miscompares++; $display("FAIL reset_first_grant got=%b want=001", src_ready);
        end
        tick();
        // Drain the output so later tests start from a known pointer/idle state.
        src_valid = '0;
        tick();
    endtask

    task automatic test_single();
        logic [N-1:0] exp;
        src_valid = '0;
        set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        exp = model_ready(src_valid, m_lg, rst);
        vectors++;
        if (src_ready !== exp || src_ready !== 3'b001) begin
            miscompares++; $display("FAIL single_ready got=%b want=%b", src_ready, exp);
        end
        tick();
        src_valid = '0;
        vectors++;
        if (write_en !== 1'b1 || write_id !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_write got we=%b id=%0d data=%h want 1/5/deadbeef", write_en, write_id, write_data);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp;
        for (int k = 0; k < N; k++) set_src(k, 1'b1, AW'(k + 1), DW'(32'hC0DE_0000 + k));
        for (int c = 0; c < 6; c++) begin
            #1;
            exp = model_ready(src_valid, m_lg, rst);
            vectors++;
            if (src_ready !== exp) begin
                miscompares++; $display("FAIL contention_ready cyc=%0d got=%b want=%b", c, src_ready, exp);
            end
            tick();
            vectors++;
            if (write_en !== m_we || write_id !== m_id || write_data !== m_data) begin
                miscompares++;
                $display("FAIL contention_write cyc=%0d got %b/%0d/%h want %b/%0d/%h",
                         c, write_en, write_id, write_data, m_we, m_id, m_data);
            end
        end
        src_valid = '0;
        tick();
    endtask

    task automatic test_x0();
        logic [N-1:0] exp;
        src_valid = '0;
        set_src(1, 1'b1, 5'd0, 32'h1234);
        #1;
        exp = model_ready(src_valid, m_lg, rst);
        vectors++;
        if (src_ready !== exp || src_ready !== 3'b010) begin
            miscompares++; $display("FAIL x0_ready got=%b want=010", src_ready);
        end
        tick();
        vectors++;
        if (write_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL x0_write_en got=%b want=0", write_en);
        end
        for (int k = 0; k < N; k++) set_src(k, 1'b1, AW'(k + 9), DW'(k));
        #1;
        vectors++;
        if (src_ready !== 3'b100) begin
            miscompares++; $display("FAIL x0_next_grant got=%b want=100", src_ready);
        end
        tick();
        src_valid = '0;
        tick();
    endtask

    task automatic test_conflict();
        // Pointer now rests at source 2; both sources target x7.
        src_valid = '0;
        set_src(0, 1'b1, 5'd7, 32'hAAAA_AAAA);
        set_src(2, 1'b1, 5'd7, 32'hBBBB_BBBB);
        #1;
        vectors++;
        if (src_ready !== 3'b001) begin
            miscompares++; $display("FAIL conflict_first_grant got=%b want=001", src_ready);
        end
        tick();
        src_valid[0] = 1'b0;
        vectors++;
        if (write_en !== 1'b1 || write_id !== 5'd7 || write_data !== 32'hAAAA_AAAA) begin
            miscompares++; $display("FAIL conflict_first_write got %b/%0d/%h want 1/7/aaaaaaaa", write_en, write_id, write_data);
        end
        tick();
        src_valid = '0;
        vectors++;
        if (write_en !== 1'b1 || write_id !== 5'd7 || write_data !== 32'hBBBB_BBBB) begin
            miscompares++; $display("FAIL conflict_second_write got %b/%0d/%h want 1/7/bbbbbbbb", write_en, write_id, write_data);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp;
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 39) != 0);
            for (int k = 0; k < N; k++)
                set_src(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3) == 0 ? 0 : $urandom), DW'($urandom));
            #1;
            exp = model_ready(src_valid, m_lg, rst);
            vectors++;
            if (src_ready !== exp) begin
                miscompares++; $display("FAIL random_ready cyc=%0d got=%b want=%b", c, src_ready, exp);
            end
            tick();
            vectors++;
            if (write_en !== m_we || busy !== m_we || write_id !== m_id || write_data !== m_data) begin
                miscompares++;
                $display("FAIL random_write cyc=%0d got %b/%0d/%h want %b/%0d/%h",
                         c, write_en, write_id, write_data, m_we, m_id, m_data);
            end
        end
        rst = 1'b1;
        src_valid = '0;
        tick();
    endtask

`ifdef WB_ARB_PERF_EN
    task automatic test_perf();
        rst = 1'b0;
        src_valid = '0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < N; k++) set_src(k, 1'b1, AW'(k + 1), DW'(k));
        for (int c = 0; c < 4; c++) tick();
        vectors++;
        if (stall_count !== 32'd8 || longint'(stall_count) != m_stall) begin
            miscompares++; $display("FAIL perf_count got=%0d want=8", stall_count);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (write_en !== 1'b0 || stall_count !== '0) begin
            miscompares++; $display("FAIL perf_reset got we=%b cnt=%0d want 0/0", write_en, stall_count);
        end
        rst = 1'b1;
        src_valid = '0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b0;
        src_valid = '0;
        src_id = '0;
        src_data = '0;
        m_lg = N - 1; m_we = 1'b0; m_id = '0; m_data = '0; m_stall = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_conflict();
        test_random();
`ifdef WB_ARB_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
